// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with valid/ready flow control and a 1-entry skid buffer.
// Optional feature macro: IMM_GEN_ZICSR_EN (CSR zimm forms decode as fmt=6, zero-extended inst[19:15]).

module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter bit PASS_INST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [31:0]     out_inst
);

    localparam logic [2:0] FMT_I    = 3'd0;
    localparam logic [2:0] FMT_S    = 3'd1;
    localparam logic [2:0] FMT_B    = 3'd2;
    localparam logic [2:0] FMT_U    = 3'd3;
    localparam logic [2:0] FMT_J    = 3'd4;
    localparam logic [2:0] FMT_NONE = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
    localparam logic [2:0] FMT_Z    = 3'd6;
`endif

    // Encoding is {out_valid, skid_valid}, so both flags come straight from the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t state, state_next;

    logic            accept;
    logic            load_out_new;
    logic            load_out_skid;
    logic            load_skid;

    logic [2:0]      dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;

    logic [XLEN-1:0] skid_imm;
    logic [2:0]      skid_fmt;
    logic [31:0]     skid_inst;
    logic [31:0]     out_inst_reg;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    assign out_valid = state[1];
    assign in_ready  = ~state[0];
    assign accept    = in_valid & in_ready;
    assign out_inst  = PASS_INST ? out_inst_reg : 32'h0;

    always_comb begin
        dec_fmt   = FMT_I;
        dec_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        case (in_inst[6:0])
            7'b0100011: begin
                dec_fmt   = FMT_S;
                dec_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt   = FMT_B;
                dec_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt   = FMT_U;
                dec_imm32 = {in_inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt   = FMT_J;
                dec_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
            end
            7'b0110011: begin
                dec_fmt   = FMT_NONE;
                dec_imm32 = 32'h0;
            end
`ifdef IMM_GEN_ZICSR_EN
            7'b1110011: begin
                if (in_inst[14]) begin
                    dec_fmt   = FMT_Z;
                    dec_imm32 = {27'b0, in_inst[19:15]};
                end
            end
`else
            7'b1110011: ;
`endif
            default: ;
        endcase
    end

    // zimm has bit 31 clear, so the common sign-extension leaves it zero-extended.
    assign dec_imm = sext32(dec_imm32);

    always_comb begin
        state_next    = state;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = BUSY;
                    load_out_new = 1'b1;
                end
            end
            BUSY: begin
                if (accept && out_ready) begin
                    load_out_new = 1'b1;
                end else if (accept) begin
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_next    = BUSY;
                    load_out_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next    = EMPTY;
            load_out_new  = 1'b0;
            load_out_skid = 1'b0;
            load_skid     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_imm      <= '0;
            out_fmt      <= 3'd0;
            out_inst_reg <= 32'h0;
        end else if (load_out_skid) begin
            out_imm      <= skid_imm;
            out_fmt      <= skid_fmt;
            out_inst_reg <= skid_inst;
        end else if (load_out_new) begin
            out_imm      <= dec_imm;
            out_fmt      <= dec_fmt;
            out_inst_reg <= in_inst;
        end
    end

    // Skid contents are only meaningful while state is FULL, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_imm  <= dec_imm;
            skid_fmt  <= dec_fmt;
            skid_inst <= in_inst;
        end
    end

endmodule
